// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, TinyVGA pin map and the colour-to-pin packing helper.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned VGA_W = 8;
    localparam int unsigned RGB_W = 6;

    // TinyVGA PMOD bit positions
    localparam int unsigned VGA_HS = 7;
    localparam int unsigned VGA_B0 = 6;
    localparam int unsigned VGA_G0 = 5;
    localparam int unsigned VGA_R0 = 4;
    localparam int unsigned VGA_VS = 3;
    localparam int unsigned VGA_B1 = 2;
    localparam int unsigned VGA_G1 = 1;
    localparam int unsigned VGA_R1 = 0;

    // rgb_in = {R[1:0],G[1:0],B[1:0]}
    localparam int unsigned RGB_R_LSB = 4;
    localparam int unsigned RGB_G_LSB = 2;
    localparam int unsigned RGB_B_LSB = 0;

    function automatic logic [VGA_W-1:0] tinyvga_pack(input logic hs, input logic vs,
                                                      input logic [RGB_W-1:0] rgb);
        logic [VGA_W-1:0] p;
        p         = '0;
        p[VGA_HS] = hs;
        p[VGA_VS] = vs;
        p[VGA_R1] = rgb[RGB_R_LSB+1];
        p[VGA_R0] = rgb[RGB_R_LSB];
        p[VGA_G1] = rgb[RGB_G_LSB+1];
        p[VGA_G0] = rgb[RGB_G_LSB];
        p[VGA_B1] = rgb[RGB_B_LSB+1];
        p[VGA_B0] = rgb[RGB_B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position/strobe bus to the graphics logic plus the colour return and pin output.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int unsigned CNT_W = 10
);
    logic [RGB_W-1:0] rgb_in;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic             display_on;
    logic             line_start;
    logic             frame_start;
    logic [VGA_W-1:0] vga_out;

    modport master (
        input  rgb_in,
        output hpos, vpos, display_on, line_start, frame_start, vga_out
    );

    modport slave (
        output rgb_in,
        input  hpos, vpos, display_on, line_start, frame_start, vga_out
    );
endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-N up counter; wrap_c flags the increment that returns it to zero.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int unsigned N = DEF_H_TOTAL,
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap_c
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap_c = inc && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap_c) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, status decodes and the registered TinyVGA pin stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    vga_timing_gen_if.master vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam logic [VGA_W-1:0] VGA_IDLE = tinyvga_pack(~SYNC_POL, ~SYNC_POL, 6'b0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             disp_c;
    logic             hsync_c;
    logic             vsync_c;
    logic [VGA_W-1:0] vga_next;
    logic [VGA_W-1:0] vga_q;

    vga_wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ena),
        .cnt    (h_cnt),
        .wrap_c (h_wrap)
    );

    // Vertical count only advances on the horizontal wrap cycle
    vga_wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ena && h_wrap),
        .cnt    (v_cnt),
        .wrap_c (v_wrap_unused)
    );

    // Raw counter-aligned syncs and next pin value; blanked colour and idle pins when paused
    always_comb begin
        disp_c   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_c  = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_c  = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vga_next = VGA_IDLE;
        if (ena) begin
            vga_next = tinyvga_pack(hsync_c, vsync_c, disp_c ? vif.rgb_in : 6'b0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_q <= VGA_IDLE;
        end else begin
            vga_q <= vga_next;
        end
    end

    assign vif.hpos        = h_cnt;
    assign vif.vpos        = v_cnt;
    assign vif.display_on  = disp_c;
    assign vif.line_start  = (h_cnt == '0);
    assign vif.frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign vif.vga_out     = vga_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- VGA raster timing generator and output pin stage for the tt_um_nvious_graphics top level.
- Sits directly upstream of the pixel/graphics logic: supplies hpos/vpos/display_on/frame and line strobes to it.
- Takes the 6-bit colour the graphics logic returns combinationally and registers it, together with the syncs, into the TinyVGA PMOD pin order that drives uo_out.
- Default timing is 640x480@60 with a 25.175 MHz (25 MHz nominal) clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  count enable (tie to top-level ena)
- rgb_in  in  6  {R[1:0],G[1:0],B[1:0]} for the current hpos/vpos; combinational from graphics logic
- hpos  out  CNT_W  current horizontal count
- vpos  out  CNT_W  current vertical count
- display_on  out  1  hpos<H_ACTIVE && vpos<V_ACTIVE
- line_start  out  1  high for the one cycle where hpos==0
- frame_start  out  1  high for the one cycle where hpos==0 && vpos==0
- vga_out  out  8  registered TinyVGA pins: [7]HS [6]B0 [5]G0 [4]R0 [3]VS [2]B1 [1]G1 [0]R1

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0.
  - vga_out = syncs at inactive level, RGB 0; default 8'h88.
- Counting (ena=1):
  - h_cnt increments every clk; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on the h wrap cycle; at V_TOTAL-1 with an h wrap, v_cnt wraps to 0.
  - No other wrap points exist.
- Status outputs:
  - hpos/vpos are the counter registers directly.
  - display_on, line_start and frame_start are combinational decodes of the counters, so they are valid in the same cycle as hpos/vpos.
- Sync windows (raw, counter-aligned):
  - hsync active when H_ACTIVE+H_FRONT <= h_cnt <= H_ACTIVE+H_FRONT+H_SYNC-1, i.e. 656..751.
  - vsync active when V_ACTIVE+V_FRONT <= v_cnt <= V_ACTIVE+V_FRONT+V_SYNC-1, i.e. 490..491, over full lines.
  - Active level is SYNC_POL; inactive level is ~SYNC_POL.
- Output stage, 1-cycle latency:
  - At each posedge, vga_out registers the raw syncs and the RGB for the counter value present before the edge. Syncs and colour therefore stay mutually aligned.
  - RGB bits are forced to 0 whenever display_on=0, regardless of rgb_in.
- ena=0:
  - Counters hold their value; strobes continue to decode the held counter (no edge detection).
  - vga_out is loaded with the idle pattern (syncs inactive, RGB 0) on the next edge.
  - On ena re-assert, counting resumes from the held position and the output stage resumes normally.
- Reset asserted mid-frame: counters and vga_out return to reset values immediately; the first frame_start follows the first clock after release.
- Simultaneous h and v wrap (h=799, v=524): both go to 0 on the same edge; frame_start is high in the following cycle.

Decomposition:
- Package vga_pkg:
  - default 640x480 timing localparams and H_TOTAL/V_TOTAL derivation;
  - TinyVGA bit-index constants (VGA_HS=7, VGA_B0=6, VGA_G0=5, VGA_R0=4, VGA_VS=3, VGA_B1=2, VGA_G1=1, VGA_R1=0);
  - rgb_in field offsets.
- One sub-module is natural: vga_wrap_counter. It is a parameterised modulo-N counter with inc input and wrap output, instantiated twice: h with inc=ena, v with inc=ena&&h_wrap.

Test Plan:
- Reset: hold rst_n=0 with clk running -> hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1, vga_out=8'h88; release -> hpos=1 after first edge.
- Horizontal timing: ena=1, count from frame_start -> raw hsync low for h=656..751; vga_out[7]=0 exactly on cycles h=657..752, i.e. one cycle late, 96 cycles wide; line_start period 800 cycles.
- Frame timing: ena=1 -> successive frame_start pulses exactly 420000 cycles apart; vga_out[3]=0 for 1600 consecutive cycles starting one cycle after (h=0,v=490).
- Blanking and pin packing:
  - rgb_in=6'b10_01_11 constant during the visible area -> vga_out=8'hED;
  - at h=640..799 the RGB bits are 0 -> vga_out=8'h88 outside the sync window;
  - rgb_in=6'b111111 -> vga_out=8'hFF in the visible area.
- Enable pause: drop ena at hpos=100,vpos=5 for 50 cycles -> hpos/vpos hold 100/5, vga_out=8'h88 from the next edge; re-assert -> hpos=101 after one edge, colour output resumes.
- Mid-frame reset and wrap corner: assert rst_n=0 at hpos=700,vpos=491 -> vga_out=8'h88 and counters 0 asynchronously, without waiting for a clock edge; separately, at h=799,v=524 the next edge yields hpos=0,vpos=0 and frame_start=1.
